// File: rtl/decode_stage.sv
// Registered RV32I decoder with a 2-entry skid buffer, illegal detection, sticky ECALL/EBREAK halt and flush.
// Optional feature: define RV32M_EN to decode the M extension (OP with funct7=0x01).
module decode_stage #(
    parameter int XLEN           = 32,
    parameter bit HALT_ON_EBREAK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      srcreg1_num,
    output logic [4:0]      srcreg2_num,
    output logic [4:0]      dstreg_num,
    output logic [XLEN-1:0] imm,
    output logic [5:0]      alucode,
    output logic [1:0]      aluop1_type,
    output logic [1:0]      aluop2_type,
    output logic            reg_we,
    output logic            is_load,
    output logic            is_store,
    output logic            is_illegal,
    output logic            is_halt
);
    localparam logic [5:0] ALU_NOP  = 6'd0,  ALU_ADD  = 6'd1,  ALU_SUB  = 6'd2,  ALU_SLL  = 6'd3;
    localparam logic [5:0] ALU_SLT  = 6'd4,  ALU_SLTU = 6'd5,  ALU_XOR  = 6'd6,  ALU_SRL  = 6'd7;
    localparam logic [5:0] ALU_SRA  = 6'd8,  ALU_OR   = 6'd9,  ALU_AND  = 6'd10, ALU_LUI  = 6'd11;
    localparam logic [5:0] ALU_BEQ  = 6'd12, ALU_BNE  = 6'd13, ALU_BLT  = 6'd14, ALU_BGE  = 6'd15;
    localparam logic [5:0] ALU_BLTU = 6'd16, ALU_BGEU = 6'd17, ALU_LB   = 6'd18, ALU_LH   = 6'd19;
    localparam logic [5:0] ALU_LW   = 6'd20, ALU_LBU  = 6'd21, ALU_LHU  = 6'd22, ALU_SB   = 6'd23;
    localparam logic [5:0] ALU_SH   = 6'd24, ALU_SW   = 6'd25, ALU_JAL  = 6'd26, ALU_JALR = 6'd27;
`ifdef RV32M_EN
    // MUL..REMU occupy 28..35 in funct3 order
    localparam logic [5:0] ALU_MUL  = 6'd28;
`endif

    localparam logic [1:0] OP_TYPE_NONE = 2'd0, OP_TYPE_REG = 2'd1, OP_TYPE_IMM = 2'd2, OP_TYPE_PC = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [5:0]      alucode;
        logic [1:0]      op1;
        logic [1:0]      op2;
        logic            reg_we;
        logic            is_load;
        logic            is_store;
        logic            is_illegal;
        logic            is_halt;
    } bundle_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [5:0] arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    assign opcode = in_ir[6:0];
    assign f3     = in_ir[14:12];
    assign f7     = in_ir[31:25];

    bundle_t dec;
    logic    we, illegal;

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rs1     = in_ir[19:15];
        dec.rs2     = in_ir[24:20];
        we          = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            7'b0010011: begin
                we = 1'b1; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_IMM;
                dec.alucode = arith(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.imm = XLEN'(in_ir[24:20]);
                    illegal = !(f7 == 7'h00 || (f3 == 3'b101 && f7 == 7'h20));
                end else begin
                    dec.imm = sext32({{20{in_ir[31]}}, in_ir[31:20]});
                end
            end
            7'b0110011: begin
                we = 1'b1; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_REG;
                if (f7 == 7'h00)
                    dec.alucode = arith(f3, 1'b0);
                else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))
                    dec.alucode = arith(f3, 1'b1);
`ifdef RV32M_EN
                else if (f7 == 7'h01)
                    dec.alucode = ALU_MUL + {3'b000, f3};
`endif
                else
                    illegal = 1'b1;
            end
            7'b0110111: begin
                we = 1'b1; dec.alucode = ALU_LUI; dec.op1 = OP_TYPE_NONE; dec.op2 = OP_TYPE_IMM;
                dec.imm = sext32({in_ir[31:12], 12'b0});
            end
            7'b0010111: begin
                we = 1'b1; dec.alucode = ALU_ADD; dec.op1 = OP_TYPE_PC; dec.op2 = OP_TYPE_IMM;
                dec.imm = sext32({in_ir[31:12], 12'b0});
            end
            7'b1101111: begin
                we = 1'b1; dec.alucode = ALU_JAL; dec.op1 = OP_TYPE_PC; dec.op2 = OP_TYPE_IMM;
                dec.imm = sext32({{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0});
            end
            7'b1100111: begin
                we = 1'b1; dec.alucode = ALU_JALR; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_IMM;
                dec.imm = sext32({{20{in_ir[31]}}, in_ir[31:20]});
            end
            7'b1100011: begin
                dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_REG;
                dec.imm = sext32({{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0});
                case (f3)
                    3'b000:  dec.alucode = ALU_BEQ;
                    3'b001:  dec.alucode = ALU_BNE;
                    3'b100:  dec.alucode = ALU_BLT;
                    3'b101:  dec.alucode = ALU_BGE;
                    3'b110:  dec.alucode = ALU_BLTU;
                    3'b111:  dec.alucode = ALU_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                we = 1'b1; dec.is_load = 1'b1; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_IMM;
                dec.imm = sext32({{20{in_ir[31]}}, in_ir[31:20]});
                case (f3)
                    3'b000:  dec.alucode = ALU_LB;
                    3'b001:  dec.alucode = ALU_LH;
                    3'b010:  dec.alucode = ALU_LW;
                    3'b100:  dec.alucode = ALU_LBU;
                    3'b101:  dec.alucode = ALU_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                dec.is_store = 1'b1; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_REG;
                dec.imm = sext32({{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]});
                case (f3)
                    3'b000:  dec.alucode = ALU_SB;
                    3'b001:  dec.alucode = ALU_SH;
                    3'b010:  dec.alucode = ALU_SW;
                    default: illegal = 1'b1;
                endcase
            end
            7'b1110011: begin
                if (in_ir == 32'h0000_0073 || (HALT_ON_EBREAK && in_ir == 32'h0010_0073))
                    dec.is_halt = 1'b1;
                else
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            we           = 1'b0;
            dec.is_load  = 1'b0;
            dec.is_store = 1'b0;
            dec.alucode  = ALU_NOP;
            dec.op1      = OP_TYPE_NONE;
            dec.op2      = OP_TYPE_NONE;
        end
        if (in_ir[11:7] == 5'd0)
            we = 1'b0;
        dec.reg_we     = we;
        dec.rd         = we ? in_ir[11:7] : 5'd0;
        dec.is_illegal = illegal;
    end

    // Entry0 feeds the outputs; entry1 absorbs the one-cycle lag of the registered in_ready.
    bundle_t e0_reg, e1_reg, e0_next, e1_next;
    logic    v0_reg, v1_reg, v0_next, v1_next;
    logic    halted_reg, halted_next, in_ready_reg, in_ready_next;
    logic    accept, consume;

    assign accept  = in_valid && in_ready_reg && !flush;
    assign consume = v0_reg && out_ready;

    always_comb begin
        e0_next     = e0_reg;
        e1_next     = e1_reg;
        v0_next     = v0_reg;
        v1_next     = v1_reg;
        halted_next = halted_reg || (accept && dec.is_halt);
        if (flush) begin
            v0_next = 1'b0;
            v1_next = 1'b0;
        end else if (consume && v1_reg) begin
            e0_next = e1_reg;
            v0_next = 1'b1;
            v1_next = accept;
            if (accept) e1_next = dec;
        end else if (consume || !v0_reg) begin
            v0_next = accept;
            if (accept) e0_next = dec;
        end else if (accept) begin
            e1_next = dec;
            v1_next = 1'b1;
        end
        in_ready_next = !v1_next && !halted_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_reg       <= '0;
            e1_reg       <= '0;
            v0_reg       <= 1'b0;
            v1_reg       <= 1'b0;
            halted_reg   <= 1'b0;
            in_ready_reg <= 1'b0;
        end else begin
            e0_reg       <= e0_next;
            e1_reg       <= e1_next;
            v0_reg       <= v0_next;
            v1_reg       <= v1_next;
            halted_reg   <= halted_next;
            in_ready_reg <= in_ready_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = v0_reg;
    assign out_pc      = e0_reg.pc;
    assign srcreg1_num = e0_reg.rs1;
    assign srcreg2_num = e0_reg.rs2;
    assign dstreg_num  = e0_reg.rd;
    assign imm         = e0_reg.imm;
    assign alucode     = e0_reg.alucode;
    assign aluop1_type = e0_reg.op1;
    assign aluop2_type = e0_reg.op2;
    assign reg_we      = e0_reg.reg_we;
    assign is_load     = e0_reg.is_load;
    assign is_store    = e0_reg.is_store;
    assign is_illegal  = e0_reg.is_illegal;
    assign is_halt     = e0_reg.is_halt;
endmodule
